bus_burst_read_master: RTL and testbench
========================================

// Module: bus_burst_read_master
// PURPOSE
//  Bus-master engine fetching a block of 32-bit words from the shared bus into a local
//  buffer port. Requests the bus from the bus arbiter, issues read bursts once granted,
//  collects read data, and splits long blocks into several bursts, re-arbitrating
//  between them. Sits between a local client (cache/DMA/accelerator) and the system bus.
// PARAMETERS
//  MAX_BURST   8      words per bus burst (power of 2, 1..256)
//  GRANT_WAIT  1023   cycles to wait for a grant before aborting with an error
// PORTS
//  clock               in   1   system clock
//  reset               in   1   asynchronous, active-low reset
//  startIn             in   1   one-cycle pulse: start block fetch (ignored unless idle)
//  startAddressIn      in   32  byte address of first word, bits [1:0] ignored
//  wordCountIn         in   9   words to fetch, 1..256 (0 treated as done, no bus traffic)
//  busyOut             out  1   high from accepted start until doneOut/errorOut
//  doneOut             out  1   one-cycle pulse: block completed successfully
//  errorOut            out  1   one-cycle pulse: block aborted (bus error / no grant)
//  bufWriteEnableOut   out  1   write strobe to local buffer
//  bufAddressOut       out  8   word index within block (0..wordCount-1)
//  bufDataOut          out  32  word to write
//  busRequestOut       out  1   request line to arbiter
//  busGrantIn          in   1   grant from arbiter (one-cycle pulse)
//  beginTransactionOut out  1   transaction start strobe
//  addressDataOut      out  32  burst address during begin cycle, else 0
//  burstSizeOut        out  8   words-1 during begin cycle, else 0
//  readNotWriteOut     out  1   1 during begin cycle, else 0
//  endTransactionOut   out  1   never asserted by a read master; tied 0
//  addressDataIn       in   32  read data from slave
//  dataValidIn         in   1   read data valid
//  busErrorIn          in   1   bus error from arbiter/slave
//  endTransactionIn    in   1   transaction end strobe
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters cleared. All bus outputs are 0 when not driving.
//  States: IDLE, REQUEST, BEGIN, RECEIVE, WAIT_END, DONE, ERROR.
//  IDLE: startIn -> latch address, count; count==0 -> DONE, else REQUEST.
//  REQUEST: busRequestOut=1; busGrantIn -> BEGIN (request drops the cycle after grant);
//    grant counter reaching GRANT_WAIT -> ERROR.
//  BEGIN: single cycle: beginTransactionOut=1, addressDataOut={addr[31:2],2'b00},
//    burstSizeOut=n-1 with n=min(remaining,MAX_BURST), readNotWriteOut=1 -> RECEIVE.
//  RECEIVE: each dataValidIn writes addressDataIn to buffer same cycle (combinational
//    strobe, registered address index), index++, remaining--. After n words -> WAIT_END.
//    endTransactionIn before n words -> ERROR (short burst).
//  WAIT_END: endTransactionIn -> remaining==0 ? DONE : REQUEST (addr += 4*n).
//    endTransactionIn coincident with last dataValidIn is accepted as completion.
//  DONE: doneOut=1 one cycle, -> IDLE. ERROR: errorOut=1 one cycle, -> IDLE.
//  busErrorIn in BEGIN/RECEIVE/WAIT_END -> ERROR; buffer writes stop immediately.
//  Bursts never cross a 256-word boundary check: address arithmetic is 32-bit wrap.
//  startIn while busy ignored. reset mid-transfer: outputs 0 immediately (async).
//  Latency: start -> busRequestOut 1 cycle; grant -> beginTransactionOut 1 cycle.
// TESTING
//  1. start addr 0x1000, count 4, grant after 3 cycles -> one begin, burstSize 3,
//     4 buffer writes idx 0..3, doneOut 1 cycle after endTransactionIn.
//  2. count 20, MAX_BURST 8 -> three bursts at 0x..00/+0x20/+0x40, sizes 7,7,3, re-request each.
//  3. no grant for 1023 cycles -> errorOut pulse, busRequestOut drops, no begin issued.
//  4. busErrorIn after 2 of 8 words -> errorOut, exactly 2 buffer writes, bus outputs 0.
//  5. endTransactionIn after 5 of 8 words -> errorOut; count 0 -> doneOut, no request.
//  6. reset low during RECEIVE -> all outputs 0 asynchronously; new start works normally.

Source files
------------

// File: rtl/bus_burst_read_master.sv
// ---------------------------------------------------------------------------
// bus_burst_read_master
//
// Bus-master engine that fetches a block of 32-bit words from the shared bus
// into a local buffer port. It requests the bus from the arbiter. Once the
// grant arrives it issues a read burst and streams the returned words into
// the buffer. Blocks longer than MAX_BURST are split into several bursts, and
// the bus is re-arbitrated between them.
//
// Parameters
//   MAX_BURST   words per bus burst (power of 2, 1..256)
//   GRANT_WAIT  cycles spent requesting without a grant before aborting
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   i_start                one-cycle start pulse (ignored unless idle)
//   i_start_address        byte address of first word, bits [1:0] ignored
//   i_word_count           words to fetch, 1..256 (0 completes with no traffic)
//   o_busy                 high while a block is in progress
//   o_done / o_error       one-cycle completion / abort pulses
//   o_buf_write_enable     local buffer write strobe (combinational)
//   o_buf_address          word index within the block
//   o_buf_data             word written to the buffer
//   o_bus_request          request line to the arbiter
//   i_bus_grant            one-cycle grant pulse from the arbiter
//   o_begin_transaction    burst start strobe
//   o_address_data         burst word address during the begin cycle, else 0
//   o_burst_size           words-1 during the begin cycle, else 0
//   o_read_not_write       1 during the begin cycle, else 0
//   o_end_transaction      never driven by a read master, tied 0
//   i_address_data         read data from the slave
//   i_data_valid           read data valid
//   i_bus_error            bus error from the arbiter or slave
//   i_end_transaction      end-of-burst strobe from the slave
// ---------------------------------------------------------------------------
module bus_burst_read_master #(
    parameter int MAX_BURST  = 8,
    parameter int GRANT_WAIT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_start_address,
    input  logic [8:0]  i_word_count,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic        o_buf_write_enable,
    output logic [7:0]  o_buf_address,
    output logic [31:0] o_buf_data,
    output logic        o_bus_request,
    input  logic        i_bus_grant,
    output logic        o_begin_transaction,
    output logic [31:0] o_address_data,
    output logic [7:0]  o_burst_size,
    output logic        o_read_not_write,
    output logic        o_end_transaction,
    input  logic [31:0] i_address_data,
    input  logic        i_data_valid,
    input  logic        i_bus_error,
    input  logic        i_end_transaction
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_BEGIN,
        S_RECEIVE,
        S_WAIT_END,
        S_DONE,
        S_ERROR
    } state_t;

    // The grant counter holds 0..GRANT_WAIT-1 while requesting.
    localparam int              GCW        = (GRANT_WAIT > 1) ? $clog2(GRANT_WAIT) : 1;
    localparam logic [GCW-1:0]  GRANT_LAST = GCW'(GRANT_WAIT - 1);
    localparam logic [8:0]      BURST_MAX  = 9'(MAX_BURST);

    state_t          r_state;
    state_t          w_next_state;

    logic [31:0]     r_addr;        // word-aligned address of the next burst
    logic [8:0]      r_remaining;   // words still to be received for the block
    logic [7:0]      r_index;       // buffer index of the next word
    logic [8:0]      r_burst_len;   // words in the current burst (n)
    logic [8:0]      r_beat;        // words received so far in the current burst
    logic [GCW-1:0]  r_grant_cnt;   // cycles spent in REQUEST

    // Datapath control strobes produced by the next-state logic.
    logic            w_accept;      // latch a new block
    logic            w_load_burst;  // capture n for the burst being granted
    logic            w_beat;        // one word accepted this cycle
    logic            w_advance;     // step the burst address past the finished burst

    logic [8:0]      w_burst_n;
    logic            w_last_beat;
    logic            w_unused_addr_bits;

    // Byte-offset bits of the start address have no function.
    assign w_unused_addr_bits = ^i_start_address[1:0];

    assign w_burst_n   = (r_remaining < BURST_MAX) ? r_remaining : BURST_MAX;
    assign w_last_beat = (r_beat == r_burst_len - 9'd1);

    // The write master side of the bus is never used.
    assign o_end_transaction = 1'b0;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        w_next_state        = r_state;
        w_accept            = 1'b0;
        w_load_burst        = 1'b0;
        w_beat              = 1'b0;
        w_advance           = 1'b0;
        o_busy              = 1'b1;
        o_done              = 1'b0;
        o_error             = 1'b0;
        o_buf_write_enable  = 1'b0;
        o_buf_address       = '0;
        o_buf_data          = '0;
        o_bus_request       = 1'b0;
        o_begin_transaction = 1'b0;
        o_address_data      = '0;
        o_burst_size        = '0;
        o_read_not_write    = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = (i_word_count == 9'd0) ? S_DONE : S_REQUEST;
                end
            end

            S_REQUEST: begin
                o_bus_request = 1'b1;
                // A grant arriving in the final waiting cycle still wins.
                if (i_bus_grant) begin
                    w_load_burst = 1'b1;
                    w_next_state = S_BEGIN;
                end else if (r_grant_cnt == GRANT_LAST) begin
                    w_next_state = S_ERROR;
                end
            end

            S_BEGIN: begin
                o_begin_transaction = 1'b1;
                o_address_data      = r_addr;
                o_burst_size        = 8'(r_burst_len - 9'd1);
                o_read_not_write    = 1'b1;
                w_next_state        = i_bus_error ? S_ERROR : S_RECEIVE;
            end

            S_RECEIVE: begin
                // A bus error suppresses the write of a word in the same cycle.
                if (i_bus_error) begin
                    w_next_state = S_ERROR;
                end else if (i_data_valid) begin
                    w_beat             = 1'b1;
                    o_buf_write_enable = 1'b1;
                    o_buf_address      = r_index;
                    o_buf_data         = i_address_data;
                    if (w_last_beat) begin
                        // End arriving with the last word completes the burst.
                        if (i_end_transaction) begin
                            w_advance    = 1'b1;
                            w_next_state = (r_remaining == 9'd1) ? S_DONE : S_REQUEST;
                        end else begin
                            w_next_state = S_WAIT_END;
                        end
                    end else if (i_end_transaction) begin
                        w_next_state = S_ERROR;
                    end
                end else if (i_end_transaction) begin
                    // Slave ended the burst before delivering n words.
                    w_next_state = S_ERROR;
                end
            end

            S_WAIT_END: begin
                if (i_bus_error) begin
                    w_next_state = S_ERROR;
                end else if (i_end_transaction) begin
                    w_advance    = 1'b1;
                    w_next_state = (r_remaining == 9'd0) ? S_DONE : S_REQUEST;
                end
            end

            S_DONE: begin
                o_done       = 1'b1;
                w_next_state = S_IDLE;
            end

            S_ERROR: begin
                o_error      = 1'b1;
                w_next_state = S_IDLE;
            end

            default: begin
                o_busy       = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_index     <= '0;
            r_burst_len <= '0;
            r_beat      <= '0;
            r_grant_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_addr      <= {i_start_address[31:2], 2'b00};
                r_remaining <= i_word_count;
                r_index     <= '0;
            end

            if (w_load_burst) begin
                r_burst_len <= w_burst_n;
                r_beat      <= '0;
            end

            if (w_beat) begin
                r_index     <= r_index + 8'd1;
                r_remaining <= r_remaining - 9'd1;
                r_beat      <= r_beat + 9'd1;
            end

            // Plain 32-bit arithmetic: a block may wrap past the top of memory.
            if (w_advance) begin
                r_addr <= r_addr + {21'd0, r_burst_len, 2'b00};
            end

            // Restarts from zero on every entry to REQUEST, because the
            // preceding state is never REQUEST.
            if (r_state == S_REQUEST) begin
                r_grant_cnt <= r_grant_cnt + GCW'(1);
            end else begin
                r_grant_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_burst_read_master.sv
// ---------------------------------------------------------------------------
// Testbench for bus_burst_read_master.
// Inputs change 1 time unit after the rising edge. Outputs are compared at
// that point, or collected by a monitor on the falling edge. The expected
// bursts and buffer writes come from a block-level model: a block of `count`
// words splits into bursts of min(remaining, MAX_BURST) words, and each burst
// starts at the previous address + 4*n.
// ---------------------------------------------------------------------------
module tb_bus_burst_read_master;

    localparam int MAX_BURST  = 8;
    localparam int GRANT_WAIT = 1023;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [31:0] i_start_address;
    logic [8:0]  i_word_count;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic        o_buf_write_enable;
    logic [7:0]  o_buf_address;
    logic [31:0] o_buf_data;
    logic        o_bus_request;
    logic        i_bus_grant;
    logic        o_begin_transaction;
    logic [31:0] o_address_data;
    logic [7:0]  o_burst_size;
    logic        o_read_not_write;
    logic        o_end_transaction;
    logic [31:0] i_address_data;
    logic        i_data_valid;
    logic        i_bus_error;
    logic        i_end_transaction;

    int checks = 0;
    int errors = 0;
    int bad_bus = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    // {address, burst size} per begin cycle; {index, data} per buffer write.
    logic [39:0] mon_begin[$];
    logic [39:0] mon_wr[$];
    logic [39:0] exp_begin[$];
    logic [39:0] exp_wr[$];

    bus_burst_read_master #(
        .MAX_BURST (MAX_BURST),
        .GRANT_WAIT(GRANT_WAIT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_start            (i_start),
        .i_start_address    (i_start_address),
        .i_word_count       (i_word_count),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_error            (o_error),
        .o_buf_write_enable (o_buf_write_enable),
        .o_buf_address      (o_buf_address),
        .o_buf_data         (o_buf_data),
        .o_bus_request      (o_bus_request),
        .i_bus_grant        (i_bus_grant),
        .o_begin_transaction(o_begin_transaction),
        .o_address_data     (o_address_data),
        .o_burst_size       (o_burst_size),
        .o_read_not_write   (o_read_not_write),
        .o_end_transaction  (o_end_transaction),
        .i_address_data     (i_address_data),
        .i_data_valid       (i_data_valid),
        .i_bus_error        (i_bus_error),
        .i_end_transaction  (i_end_transaction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: records bus and buffer activity, and counts bus outputs that
    // are non-zero outside a begin cycle.
    always @(negedge clk) begin
        if (o_begin_transaction === 1'b1) begin
            mon_begin.push_back({o_address_data, o_burst_size});
            if (o_read_not_write !== 1'b1) bad_bus++;
        end else if (o_address_data !== 32'd0 || o_burst_size !== 8'd0 ||
                     o_read_not_write !== 1'b0) begin
            bad_bus++;
        end
        if (o_end_transaction !== 1'b0) bad_bus++;
        if (o_buf_write_enable === 1'b1) mon_wr.push_back({o_buf_address, o_buf_data});
        if (o_done === 1'b1) done_cnt++;
        if (o_error === 1'b1) err_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (checks=%0d errors=%0d)",
                 checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_and_clear(input string tag);
        check({tag, "_burst_count"}, 64'(mon_begin.size()), 64'(exp_begin.size()));
        for (int i = 0; i < exp_begin.size(); i++)
            if (i < mon_begin.size()) check({tag, "_burst"}, mon_begin[i], exp_begin[i]);
        check({tag, "_write_count"}, 64'(mon_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size(); i++)
            if (i < mon_wr.size()) check({tag, "_write"}, mon_wr[i], exp_wr[i]);
        mon_begin.delete();
        mon_wr.delete();
        exp_begin.delete();
        exp_wr.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic start_block(input logic [31:0] addr, input int count);
        i_start         = 1'b1;
        i_start_address = addr;
        i_word_count    = 9'(count);
        step();
        i_start         = 1'b0;
        // Scramble the operands so a DUT that keeps sampling them is exposed.
        i_start_address = $urandom;
        i_word_count    = 9'($urandom);
    endtask

    // Grant immediately and return once the DUT is in its data phase.
    task automatic grant_and_begin(input logic [31:0] addr, input int n);
        i_bus_grant = 1'b1;
        step();
        i_bus_grant = 1'b0;
        exp_begin.push_back({addr, 8'(n - 1)});
        step();
    endtask

    task automatic send_word(input int idx);
        logic [31:0] d;
        d              = $urandom;
        i_data_valid   = 1'b1;
        i_address_data = d;
        exp_wr.push_back({8'(idx), d});
        step();
        i_data_valid   = 1'b0;
    endtask

    // Complete block fetch with a well-behaved arbiter and slave.
    task automatic run_clean_block(input string tag, input logic [31:0] addr, input int count,
                                   input int gmin, input int gmax);
        logic [31:0] a;
        logic [31:0] d;
        int          rem;
        int          idx;
        int          n;
        bit          coincide;
        a   = {addr[31:2], 2'b00};
        rem = count;
        idx = 0;
        start_block(addr, count);
        check({tag, "_busy"}, 64'(o_busy), 64'd1);
        while (rem > 0) begin
            n = (rem < MAX_BURST) ? rem : MAX_BURST;
            exp_begin.push_back({a, 8'(n - 1)});
            check({tag, "_req_latency"}, 64'(o_bus_request), 64'd1);
            repeat ($urandom_range(gmax, gmin)) step();
            i_bus_grant = 1'b1;
            step();
            i_bus_grant = 1'b0;
            check({tag, "_begin_latency"}, 64'(o_begin_transaction), 64'd1);
            check({tag, "_req_drop"}, 64'(o_bus_request), 64'd0);
            step();
            coincide = 1'($urandom_range(1, 0));
            for (int b = 0; b < n; b++) begin
                repeat ($urandom_range(2, 0)) step();
                d              = $urandom;
                i_data_valid   = 1'b1;
                i_address_data = d;
                exp_wr.push_back({8'(idx), d});
                idx++;
                if (b == n - 1 && coincide) i_end_transaction = 1'b1;
                step();
                i_data_valid      = 1'b0;
                i_end_transaction = 1'b0;
            end
            if (!coincide) begin
                repeat ($urandom_range(2, 0)) step();
                i_end_transaction = 1'b1;
                step();
                i_end_transaction = 1'b0;
            end
            rem -= n;
            a   += 32'(4 * n);
        end
        check({tag, "_done"}, 64'(o_done), 64'd1);
        step();
        check({tag, "_done_one_cycle"}, 64'(o_done), 64'd0);
        check({tag, "_idle"}, 64'(o_busy), 64'd0);
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_no_error"}, 64'(err_cnt), 64'd0);
        compare_and_clear(tag);
    endtask

    initial begin
        int req_cycles;
        bit seen;

        rst_n             = 1'b0;
        i_start           = 1'b0;
        i_start_address   = '0;
        i_word_count      = '0;
        i_bus_grant       = 1'b0;
        i_address_data    = '0;
        i_data_valid      = 1'b0;
        i_bus_error       = 1'b0;
        i_end_transaction = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_req", 64'(o_bus_request), 64'd0);
        check("rst_begin", 64'(o_begin_transaction), 64'd0);
        check("rst_flags", 64'({o_done, o_error, o_buf_write_enable}), 64'd0);

        // Single 4-word burst, grant after 3 cycles
        run_clean_block("t1", 32'h0000_1000, 4, 3, 3);

        // 20 words split into 8+8+4
        run_clean_block("t2", 32'h0000_4003, 20, 0, 2);

        // Boundaries: exactly one full burst, one word past it, address wrap, max block
        run_clean_block("full8", 32'h0000_0200, 8, 0, 1);
        run_clean_block("nine", 32'h0000_0300, 9, 0, 1);
        run_clean_block("wrap", 32'hFFFF_FFF0, 12, 0, 1);
        run_clean_block("max256", 32'h0001_0000, 256, 0, 0);

        // Randomized blocks
        for (int k = 0; k < 6; k++)
            run_clean_block("rand", $urandom, $urandom_range(40, 1), 0, 4);

        // No grant: abort after GRANT_WAIT requesting cycles
        start_block(32'h0000_5000, 4);
        req_cycles = 0;
        seen       = 1'b0;
        for (int c = 0; c < GRANT_WAIT + 20; c++) begin
            if (o_error === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (o_bus_request === 1'b1) req_cycles++;
            step();
        end
        check("t3_error_seen", 64'(seen), 64'd1);
        check("t3_req_cycles", 64'(req_cycles), 64'(GRANT_WAIT));
        check("t3_req_drop", 64'(o_bus_request), 64'd0);
        step();
        check("t3_error_one_cycle", 64'(o_error), 64'd0);
        check("t3_error_count", 64'(err_cnt), 64'd1);
        compare_and_clear("t3");

        // Bus error during the third word of 8: only two words written
        start_block(32'h0000_2000, 8);
        grant_and_begin(32'h0000_2000, 8);
        send_word(0);
        send_word(1);
        i_data_valid   = 1'b1;
        i_bus_error    = 1'b1;
        i_address_data = $urandom;
        #1;
        check("t4_write_blocked", 64'(o_buf_write_enable), 64'd0);
        step();
        i_data_valid = 1'b0;
        i_bus_error  = 1'b0;
        check("t4_error", 64'(o_error), 64'd1);
        check("t4_bus_zero", 64'({o_address_data, o_bus_request, o_begin_transaction}), 64'd0);
        step();
        check("t4_idle", 64'({o_error, o_busy}), 64'd0);
        check("t4_error_count", 64'(err_cnt), 64'd1);
        compare_and_clear("t4");

        // Short burst: end after 5 of 8 words; a start during the burst is ignored
        start_block(32'h0000_3000, 8);
        grant_and_begin(32'h0000_3000, 8);
        i_start      = 1'b1;
        i_word_count = 9'd0;
        send_word(0);
        i_start = 1'b0;
        for (int w = 1; w < 5; w++) send_word(w);
        i_end_transaction = 1'b1;
        step();
        i_end_transaction = 1'b0;
        check("t5_error", 64'(o_error), 64'd1);
        step();
        check("t5_counts", 64'({done_cnt[7:0], err_cnt[7:0]}), 64'h0001);
        compare_and_clear("t5");

        // Zero-length block: done with no bus traffic
        start_block(32'h0000_6000, 0);
        check("t5z_done", 64'(o_done), 64'd1);
        check("t5z_no_req", 64'(o_bus_request), 64'd0);
        step();
        check("t5z_idle", 64'({o_done, o_busy, o_bus_request}), 64'd0);
        check("t5z_done_count", 64'(done_cnt), 64'd1);
        compare_and_clear("t5z");

        // Asynchronous reset in the middle of a burst
        start_block(32'h0000_7000, 8);
        grant_and_begin(32'h0000_7000, 8);
        send_word(0);
        send_word(1);
        i_data_valid   = 1'b1;
        i_address_data = 32'hDEAD_BEEF;
        #2;
        check("t6_writing", 64'(o_buf_write_enable), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_we", 64'(o_buf_write_enable), 64'd0);
        check("t6_async_outs",
              64'({o_busy, o_bus_request, o_begin_transaction, o_buf_address, o_buf_data}),
              64'd0);
        i_data_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        mon_begin.delete();
        mon_wr.delete();
        exp_begin.delete();
        exp_wr.delete();
        done_cnt = 0;
        err_cnt  = 0;
        run_clean_block("t6_after", 32'h0000_8000, 11, 0, 2);

        check("bus_idle_zero", 64'(bad_bus), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
